sevseg_mux_n: RTL
=================

Name: sevseg_mux_n

Overview:
- Parametrised multiplexed 7-segment display driver for NDIG common-cathode/anode digits, with double-buffered display registers.
- Adds hex decode with per-digit decimal point, leading-zero blanking, PWM brightness, anti-ghosting dead time and a frame-synchronous LOAD commit, so the display never tears.
- Sits between a UART/com command block and the Pmod header; the top level maps SEG/SEG_DP/DIG_EN onto the pins.

Parameters:
- NDIG, 4, number of digits (1..8).
- DIV, 12000, CLK cycles per digit slot (>= DEAD+2).
- DEAD, 16, cycles at slot start with all digits disabled.
- BRIGHT_W, 4, width of the brightness control.
- SEG_POL, 1, active level of SEG/SEG_DP (1 = active-high).
- DIG_POL, 1, active level of DIG_EN.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- LOAD  in  1  single-cycle strobe; capture DATA/DP into the pending buffer.
- DATA  in  4*NDIG  hex nibbles; [3:0] = digit 0 (least significant, rightmost).
- DP  in  NDIG  decimal point per digit.
- BLANK_LZ  in  1  leading-zero blanking enable (sampled live).
- BRIGHT  in  BRIGHT_W  duty control (sampled live).
- PENDING  out  1  pending buffer not yet committed.
- FRAME  out  1  one-cycle pulse at each frame wrap.
- SEG  out  7  segments, bit0 = a ... bit6 = g.
- SEG_DP  out  1  decimal-point segment.
- DIG_EN  out  NDIG  digit enables, one-hot or all inactive.

Behaviour:
- Clock and reset: one clock (CLK). Reset is asynchronous, active-low (RST_N).
- Reset values:
  - slot counter = 0, digit index = 0, pwm counter = 0.
  - active and pending buffers = 0; PENDING = 0; FRAME = 0.
  - SEG, SEG_DP and DIG_EN all at their inactive level.
  - Reset mid-frame or mid-load discards the pending data.
- Slot counter cnt runs 0..DIV-1. At DIV-1 it wraps and idx advances 0..NDIG-1, then wraps to 0.
- Frame end (cnt = DIV-1 and idx = NDIG-1):
  - FRAME pulses on the following cycle.
  - If PENDING, the pending buffer is copied to the active buffer and PENDING clears.
- LOAD:
  - Writes pending, sets PENDING.
  - A repeated LOAD before commit overwrites pending (last wins).
  - LOAD on the frame-end cycle: DATA/DP go directly to active, and PENDING ends at 0.
- Decode (hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Leading-zero blanking: when BLANK_LZ=1, digit k>0 is blanked (SEG=00) if nibbles k..NDIG-1 are all zero.
  - Digit 0 is never blanked.
  - DP is unaffected by blanking.
- PWM: a free-running BRIGHT_W-bit counter increments every cycle.
  - on = (pwm < BRIGHT) or (BRIGHT = all ones).
  - BRIGHT = 0 keeps every digit off.
- DIG_EN[idx] is active iff cnt >= DEAD and on; all other bits are inactive.
- SEG/SEG_DP always carry the active-buffer code for idx, independent of the enable.
- Pipeline: all outputs are registered, one cycle after the cnt/idx/pwm state that produced them.
- Polarity: outputs are XORed with the inactive level per SEG_POL/DIG_POL.

Decomposition:
- Shared include sevseg_defs.vh holds the 16 segment code constants, SEG_BLANK, and the segment bit-order definition.
- One combinational sub-module, sevseg_enc: 4-bit nibble + blank -> 7-bit code. Instantiate it once, muxed by idx.
- Counters, buffers and output registers stay in sevseg_mux_n.

Test Plan:
- Reset scan: NDIG=4, DIV=8, DEAD=2, BRIGHT=F, hold RST_N=0 then release.
  - DIG_EN is 0000 during reset and for cycles 0-2 after release.
  - It then shows 0001 for 6 cycles, 0010 for 6 cycles, and so on.
  - FRAME pulses every 32 cycles.
- Decode: LOAD DATA=16'h1A3F, DP=4'b0100.
  - After the next FRAME: digit0 SEG=71, digit1 SEG=4F, digit2 SEG=77 with SEG_DP=1, digit3 SEG=06.
- Tear-free commit: LOAD mid-frame.
  - PENDING=1 and the old digits persist until frame end; the new values appear starting at digit 0 of the next frame.
  - LOAD on the frame-end cycle: PENDING stays 0 and the new values show immediately.
- Leading-zero blanking: DATA=16'h0050, BLANK_LZ=1 -> digits 3,2 SEG=00, digit1=6D, digit0=3F. DATA=0 -> only digit0 lit (3F).
- Brightness: BRIGHT=4 -> exactly 4 of every 16 cycles enabled within the slot's active window. BRIGHT=0 -> DIG_EN never active.
- Async reset mid-frame: drop RST_N at idx=2, cnt=5 with PENDING=1.
  - Outputs go inactive in the same cycle without waiting for a CLK edge.
  - After release, the display shows 0 and PENDING=0.

Source files
------------

// File: rtl/sevseg_mux_n_pkg.sv
// Shared definitions for the multiplexed seven-segment driver.
// Segment codes are active-high with bit0 = a ... bit6 = g.
package sevseg_mux_n_pkg;

    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_bit_e;

    localparam int SEG_W = int'(SEG_G) + 1;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h71;

    function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nibble);
        logic [SEG_W-1:0] code;
        case (nibble)
            4'h0:    code = SEG_HEX_0;
            4'h1:    code = SEG_HEX_1;
            4'h2:    code = SEG_HEX_2;
            4'h3:    code = SEG_HEX_3;
            4'h4:    code = SEG_HEX_4;
            4'h5:    code = SEG_HEX_5;
            4'h6:    code = SEG_HEX_6;
            4'h7:    code = SEG_HEX_7;
            4'h8:    code = SEG_HEX_8;
            4'h9:    code = SEG_HEX_9;
            4'hA:    code = SEG_HEX_A;
            4'hB:    code = SEG_HEX_B;
            4'hC:    code = SEG_HEX_C;
            4'hD:    code = SEG_HEX_D;
            4'hE:    code = SEG_HEX_E;
            default: code = SEG_HEX_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sevseg_enc.sv
// Combinational hex-to-segment encoder with a blanking override.
module sevseg_enc
    import sevseg_mux_n_pkg::*;
(
    input  logic [3:0]       i_nibble,
    input  logic             i_blank,
    output logic [SEG_W-1:0] o_seg
);

    always_comb begin
        o_seg = i_blank ? SEG_BLANK : seg_decode(i_nibble);
    end

endmodule

// File: rtl/sevseg_mux_n.sv
// Time-multiplexed NDIG-digit seven-segment driver with double-buffered data,
// leading-zero blanking, PWM brightness, dead time and frame-synchronous commit.
module sevseg_mux_n
    import sevseg_mux_n_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int DIV      = 12000,
    parameter int DEAD     = 16,
    parameter int BRIGHT_W = 4,
    parameter int SEG_POL  = 1,
    parameter int DIG_POL  = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic [4*NDIG-1:0]   i_data,
    input  logic [NDIG-1:0]     i_dp,
    input  logic                i_blank_lz,
    input  logic [BRIGHT_W-1:0] i_bright,
    output logic                o_pending,
    output logic                o_frame,
    output logic [SEG_W-1:0]    o_seg,
    output logic                o_seg_dp,
    output logic [NDIG-1:0]     o_dig_en
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD  = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIG - 1);

    // Inactive levels; every output is its active-high value XORed with these.
    localparam logic [SEG_W-1:0] SEG_INACT = (SEG_POL != 0) ? '0 : '1;
    localparam logic             DP_INACT  = (SEG_POL == 0);
    localparam logic [NDIG-1:0]  DIG_INACT = (DIG_POL != 0) ? '0 : '1;

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [BRIGHT_W-1:0] r_pwm;

    logic [4*NDIG-1:0]   r_act_data;
    logic [NDIG-1:0]     r_act_dp;
    logic [4*NDIG-1:0]   r_pend_data;
    logic [NDIG-1:0]     r_pend_dp;
    logic                r_pending;

    logic                r_frame;
    logic [SEG_W-1:0]    r_seg;
    logic                r_seg_dp;
    logic [NDIG-1:0]     r_dig_en;

    logic                w_cnt_last;
    logic                w_frame_end;
    logic                w_on;
    logic                w_window;
    logic [3:0]          w_nib [NDIG];
    logic [NDIG-1:0]     w_lz;
    logic [NDIG-1:0]     w_dig_sel;
    logic [NDIG-1:0]     w_dig_en;
    logic [3:0]          w_cur_nib;
    logic                w_cur_blank;
    logic                w_cur_dp;
    logic [SEG_W-1:0]    w_cur_seg;

    assign w_cnt_last  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_cnt_last && (r_idx == IDX_LAST);

    // Per-digit nibble, blanking flag and slot select.
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            assign w_nib[gi]     = r_act_data[4*gi +: 4];
            assign w_dig_sel[gi] = (r_idx == IDX_W'(gi));
            if (gi == 0) begin : g_lsd
                assign w_lz[gi] = 1'b0;
            end else begin : g_upper
                // Blank when this nibble and every more-significant one is zero.
                assign w_lz[gi] = i_blank_lz && (r_act_data[4*NDIG-1:4*gi] == '0);
            end
        end
    endgenerate

    always_comb begin
        w_cur_nib   = '0;
        w_cur_blank = 1'b0;
        w_cur_dp    = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (w_dig_sel[k]) begin
                w_cur_nib   = w_nib[k];
                w_cur_blank = w_lz[k];
                w_cur_dp    = r_act_dp[k];
            end
        end
    end

    sevseg_enc u_enc (
        .i_nibble (w_cur_nib),
        .i_blank  (w_cur_blank),
        .o_seg    (w_cur_seg)
    );

    // All-ones brightness means fully on rather than one step short of it.
    assign w_on     = (r_pwm < i_bright) || (&i_bright);
    assign w_window = (r_cnt >= CNT_DEAD);
    assign w_dig_en = (w_window && w_on) ? w_dig_sel : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
            if (w_cnt_last) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A LOAD landing on the frame-end cycle bypasses the pending stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act_data  <= '0;
            r_act_dp    <= '0;
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_pending   <= 1'b0;
        end else if (i_load && w_frame_end) begin
            r_act_data <= i_data;
            r_act_dp   <= i_dp;
            r_pending  <= 1'b0;
        end else if (i_load) begin
            r_pend_data <= i_data;
            r_pend_dp   <= i_dp;
            r_pending   <= 1'b1;
        end else if (w_frame_end && r_pending) begin
            r_act_data <= r_pend_data;
            r_act_dp   <= r_pend_dp;
            r_pending  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame  <= 1'b0;
            r_seg    <= SEG_INACT;
            r_seg_dp <= DP_INACT;
            r_dig_en <= DIG_INACT;
        end else begin
            r_frame  <= w_frame_end;
            r_seg    <= w_cur_seg ^ SEG_INACT;
            r_seg_dp <= w_cur_dp ^ DP_INACT;
            r_dig_en <= w_dig_en ^ DIG_INACT;
        end
    end

    assign o_pending = r_pending;
    assign o_frame   = r_frame;
    assign o_seg     = r_seg;
    assign o_seg_dp  = r_seg_dp;
    assign o_dig_en  = r_dig_en;

endmodule
